// File: rtl/decode_stage_reg_if.sv
// Handshake and control-bundle signals between the IF/ID stage and the registered decoder.
interface decode_stage_reg_if;
    logic [15:0] instruction;
    logic        in_valid;
    logic        stall;
    logic        flush_in;
    logic        out_valid;
    logic        killed;
    logic        illegal;
    logic [2:0]  destination;
    logic [2:0]  source_a;
    logic [2:0]  source_b;
    logic [1:0]  alu_b;
    logic [1:0]  imm_ctrl;
    logic [1:0]  r7_write_mux;
    logic [1:0]  out_mux_sel;
    logic [5:0]  alu_op;
    logic        reg_write_en;
    logic        datamem_write_en;
    logic        datamem_read_en;
    logic        mem_alu;
    logic        r7_write_en;
    logic        instr_flush;
    logic        instr_flush_2;

    modport master (
        output instruction, in_valid, stall, flush_in,
        input  out_valid, killed, illegal, destination, source_a, source_b,
               alu_b, imm_ctrl, r7_write_mux, out_mux_sel, alu_op,
               reg_write_en, datamem_write_en, datamem_read_en, mem_alu,
               r7_write_en, instr_flush, instr_flush_2
    );

    modport slave (
        input  instruction, in_valid, stall, flush_in,
        output out_valid, killed, illegal, destination, source_a, source_b,
               alu_b, imm_ctrl, r7_write_mux, out_mux_sel, alu_op,
               reg_write_en, datamem_write_en, datamem_read_en, mem_alu,
               r7_write_en, instr_flush, instr_flush_2
    );
endinterface

// File: rtl/decode_stage_reg.sv
// ID->RR pipeline register: decodes one instruction per accepted cycle and kills
// instructions falling in the shadow of a taken control transfer.
module decode_stage_reg #(
    parameter int SHADOW_JMP = 1,
    parameter int SHADOW_BR  = 2,
    parameter int CNT_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    decode_stage_reg_if.slave bus
);

    typedef struct packed {
        logic [2:0] dest;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [1:0] alu_b;
        logic [5:0] alu_op;
        logic [1:0] imm_ctrl;
        logic [1:0] out_mux_sel;
        logic [1:0] r7_write_mux;
        logic       rwe;
        logic       dwe;
        logic       dre;
        logic       mem_alu;
        logic       r7we;
        logic       flush;
        logic       flush2;
        logic       illegal;
    } bundle_t;

    localparam logic [CNT_W-1:0] LP_SH_JMP = CNT_W'(SHADOW_JMP);
    localparam logic [CNT_W-1:0] LP_SH_BR  = CNT_W'(SHADOW_BR);

    function automatic bundle_t decode(input logic [15:0] ins);
        bundle_t    b;
        logic [3:0] op;
        logic [1:0] cz;
        op = ins[15:12];
        cz = ins[1:0];
        b  = '0;
        case (op)
            4'b0101: begin
                b.dest = ins[5:3];  b.src_a = ins[8:6];  b.src_b = ins[11:9];
            end
            4'b0100, 4'b0011, 4'b1001, 4'b1010: begin
                b.dest = ins[11:9]; b.src_a = ins[8:6];  b.src_b = ins[5:3];
            end
            4'b0000: begin
                b.dest = ins[8:6];  b.src_a = ins[11:9]; b.src_b = ins[5:3];
            end
            default: begin
                b.dest = ins[5:3];  b.src_a = ins[11:9]; b.src_b = ins[8:6];
            end
        endcase
        case (op)
            4'b0001: begin
                b.rwe = 1'b1; b.mem_alu = 1'b1;
                case (cz)
                    2'b00:   begin b.alu_b = 2'b01; b.alu_op = 6'b001100; end
                    2'b01:   begin b.alu_b = 2'b01; b.alu_op = 6'b001101; end
                    2'b10:   begin b.alu_b = 2'b01; b.alu_op = 6'b001110; end
                    default: begin b.alu_b = 2'b00; b.alu_op = 6'b001100; end
                endcase
            end
            4'b0000: begin
                b.alu_b = 2'b10; b.alu_op = 6'b001100; b.rwe = 1'b1; b.mem_alu = 1'b1;
            end
            4'b0010: begin
                if (cz == 2'b11) begin
                    b.illegal = 1'b1;
                end else begin
                    b.alu_b = 2'b01; b.alu_op = {4'b0101, cz};
                    b.rwe = 1'b1; b.mem_alu = 1'b1;
                end
            end
            4'b0011: begin
                b.alu_op = 6'b010101; b.imm_ctrl = 2'b01; b.out_mux_sel = 2'b01;
                b.rwe = 1'b1; b.mem_alu = 1'b1;
            end
            4'b0100: begin
                b.alu_b = 2'b10; b.alu_op = 6'b000100; b.rwe = 1'b1; b.dre = 1'b1;
            end
            4'b0101: begin
                b.alu_b = 2'b10; b.alu_op = 6'b000100; b.dwe = 1'b1;
            end
            4'b1000: begin
                b.alu_b = 2'b01; b.alu_op = 6'b100101;
                b.r7we = 1'b1; b.flush = 1'b1; b.flush2 = 1'b1;
            end
            4'b1001: begin
                b.imm_ctrl = 2'b10; b.out_mux_sel = 2'b10;
                b.rwe = 1'b1; b.mem_alu = 1'b1; b.r7we = 1'b1; b.flush = 1'b1;
            end
            4'b1010: begin
                b.imm_ctrl = 2'b11; b.out_mux_sel = 2'b10; b.r7_write_mux = 2'b01;
                b.rwe = 1'b1; b.mem_alu = 1'b1; b.r7we = 1'b1; b.flush = 1'b1;
            end
            4'b1011: begin
                b.imm_ctrl = 2'b10; b.r7_write_mux = 2'b10;
                b.r7we = 1'b1; b.flush = 1'b1; b.flush2 = 1'b1;
            end
            default: b.illegal = 1'b1;
        endcase
        return b;
    endfunction

    logic [3:0]       w_op_p0;
    logic             w_is_jmp_p0;
    logic             w_is_br_p0;
    logic             w_kill_p0;
    logic [CNT_W-1:0] w_sh_nxt_p0;
    bundle_t          w_dec_p0;
    bundle_t          w_bun_p0;

    logic [CNT_W-1:0] r_sh;
    logic             r_vld_p1;
    logic             r_killed_p1;
    bundle_t          r_bun_p1;

    assign w_op_p0     = bus.instruction[15:12];
    assign w_is_jmp_p0 = (w_op_p0 == 4'b1001) || (w_op_p0 == 4'b1010);
    assign w_is_br_p0  = (w_op_p0 == 4'b1011) || (w_op_p0 == 4'b1000);
    assign w_kill_p0   = (r_sh != '0);
    assign w_dec_p0    = decode(bus.instruction);

    always_comb begin
        w_bun_p0    = w_dec_p0;
        w_sh_nxt_p0 = r_sh;
        if (w_kill_p0) begin
            // Shadowed instructions keep their decode for visibility but lose every side effect.
            w_bun_p0.rwe    = 1'b0;
            w_bun_p0.dwe    = 1'b0;
            w_bun_p0.dre    = 1'b0;
            w_bun_p0.r7we   = 1'b0;
            w_bun_p0.flush  = 1'b0;
            w_bun_p0.flush2 = 1'b0;
            w_sh_nxt_p0     = r_sh - CNT_W'(1);
        end else if (w_is_jmp_p0) begin
            w_sh_nxt_p0 = LP_SH_JMP;
        end else if (w_is_br_p0) begin
            w_sh_nxt_p0 = LP_SH_BR;
        end
    end

    // ---- stage p0 -> p1 register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_killed_p1 <= 1'b0;
            r_sh        <= '0;
            r_bun_p1    <= '0;
        end else if (bus.flush_in) begin
            r_vld_p1 <= 1'b0;
            r_sh     <= '0;
        end else if (!bus.stall) begin
            if (bus.in_valid) begin
                r_vld_p1    <= 1'b1;
                r_killed_p1 <= w_kill_p0;
                r_bun_p1    <= w_bun_p0;
                r_sh        <= w_sh_nxt_p0;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid        = r_vld_p1;
    assign bus.killed           = r_killed_p1;
    assign bus.illegal          = r_bun_p1.illegal;
    assign bus.destination      = r_bun_p1.dest;
    assign bus.source_a         = r_bun_p1.src_a;
    assign bus.source_b         = r_bun_p1.src_b;
    assign bus.alu_b            = r_bun_p1.alu_b;
    assign bus.alu_op           = r_bun_p1.alu_op;
    assign bus.imm_ctrl         = r_bun_p1.imm_ctrl;
    assign bus.out_mux_sel      = r_bun_p1.out_mux_sel;
    assign bus.r7_write_mux     = r_bun_p1.r7_write_mux;
    assign bus.mem_alu          = r_bun_p1.mem_alu;
    assign bus.reg_write_en     = r_vld_p1 & r_bun_p1.rwe;
    assign bus.datamem_write_en = r_vld_p1 & r_bun_p1.dwe;
    assign bus.datamem_read_en  = r_vld_p1 & r_bun_p1.dre;
    assign bus.r7_write_en      = r_vld_p1 & r_bun_p1.r7we;
    assign bus.instr_flush      = r_vld_p1 & r_bun_p1.flush;
    assign bus.instr_flush_2    = r_vld_p1 & r_bun_p1.flush2;

endmodule
